// File: rtl/ber_seq_pkg.sv
// Shared definitions for the BER sequencer: state encoding, default PRBS
// period and width helpers for the symbol and period counters.
package ber_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_COUNT = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    localparam int DEFAULT_PRBS_LEN = 511;

    // Smallest symbol-counter width that can hold a full alignment sweep.
    function automatic int min_cnt_width(input int prbs_len);
        return $clog2(prbs_len * prbs_len + 1);
    endfunction

    function automatic int period_width(input int prbs_len);
        return (prbs_len > 1) ? $clog2(prbs_len) : 1;
    endfunction

endpackage

// File: rtl/prbs_period_counter.sv
// Modulo-LEN counter with enable, synchronous clear and terminal-count flag;
// also used to walk the PRBS comparator address.
module prbs_period_counter
    import ber_seq_pkg::*;
#(
    parameter int LEN = DEFAULT_PRBS_LEN,
    parameter int W   = period_width(LEN)
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         terminal
);

    localparam logic [W-1:0] LAST = W'(LEN - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    assign terminal = (count_reg == LAST);
    assign count    = count_reg;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (en) begin
            count_next = terminal ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/ber_sequencer.sv
// BER test phase sequencer: IDLE -> WAIT -> SYNC -> COUNT -> DONE/FAIL.
// Define BER_SEQUENCER_EARLY_EXIT_EN to leave SYNC at the first locked period boundary.
module ber_sequencer
    import ber_seq_pkg::*;
#(
    parameter int PRBS_LEN  = DEFAULT_PRBS_LEN,
    parameter int NUM_LANES = 2,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_en_rx,
    input  logic                 i_ctrl,
    input  logic                 i_restart,
    input  logic [CNT_W-1:0]     i_wait_len,
    input  logic [CNT_W-1:0]     i_cnt_len,
    input  logic [NUM_LANES-1:0] i_lock,
    output logic                 o_start_synchro,
    output logic                 o_prbs_cmp_curr_addr_done,
    output logic                 o_start_ber_counter,
    output logic                 o_done,
    output logic                 o_sync_fail,
    output logic [2:0]           o_state
);

    localparam int                PW          = period_width(PRBS_LEN);
    localparam logic [CNT_W-1:0]  SWEEP_LAST  = CNT_W'(PRBS_LEN * PRBS_LEN - 1);
    localparam logic [PW-1:0]     PERIOD_LAST = PW'(PRBS_LEN - 1);

    generate
        if (CNT_W < min_cnt_width(PRBS_LEN)) begin : g_bad_cnt_w
            $error("CNT_W too narrow for a PRBS_LEN*PRBS_LEN sweep");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] sym_cnt_reg, sym_cnt_next;
    logic [CNT_W-1:0] wait_len_reg, wait_len_next;
    logic [CNT_W-1:0] cnt_len_reg, cnt_len_next;
    logic [PW-1:0]    period_cnt;
    logic             period_term;
    logic             all_locked;
    logic             restart_req;
    logic             entry;
    logic             counting;
    logic             sweep_end;

    assign all_locked  = &i_lock;
    assign restart_req = i_en_rx && i_restart && (state_reg != ST_IDLE);
    // Symbol and period counters reach their terminal values together.
    assign sweep_end   = period_term && (sym_cnt_reg == SWEEP_LAST);
    assign counting    = (state_reg == ST_WAIT) || (state_reg == ST_SYNC) ||
                         (state_reg == ST_COUNT);

    prbs_period_counter #(
        .LEN (PRBS_LEN),
        .W   (PW)
    ) u_period (
        .clk      (clk),
        .srst     (i_reset),
        .clear    (entry || (state_reg != ST_SYNC)),
        .en       (i_ctrl && (state_reg == ST_SYNC)),
        .count    (period_cnt),
        .terminal (period_term)
    );

    always_comb begin
        state_next = state_reg;
        if (!i_en_rx) begin
            state_next = ST_IDLE;
        end else if (restart_req) begin
            state_next = ST_WAIT;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_WAIT;
                ST_WAIT: begin
                    if (wait_len_reg == '0) begin
                        state_next = ST_SYNC;
                    end else if (i_ctrl && (sym_cnt_reg == wait_len_reg - CNT_W'(1))) begin
                        state_next = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (i_ctrl) begin
                        if (sweep_end) begin
                            state_next = all_locked ? ST_COUNT : ST_FAIL;
                        end
`ifdef BER_SEQUENCER_EARLY_EXIT_EN
                        else if (period_term && all_locked) begin
                            state_next = ST_COUNT;
                        end
`endif
                    end
                end
                ST_COUNT: begin
                    if (i_ctrl && (cnt_len_reg != '0) &&
                        (sym_cnt_reg == cnt_len_reg - CNT_W'(1))) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE, ST_FAIL: state_next = state_reg;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign entry = (state_next != state_reg) || restart_req;

    always_comb begin
        sym_cnt_next  = sym_cnt_reg;
        wait_len_next = wait_len_reg;
        cnt_len_next  = cnt_len_reg;
        if (entry || !i_en_rx) begin
            sym_cnt_next = '0;
        end else if (i_ctrl && counting && (sym_cnt_reg != '1)) begin
            // Saturates so an unbounded COUNT window never wraps.
            sym_cnt_next = sym_cnt_reg + CNT_W'(1);
        end
        if (entry && (state_next == ST_WAIT)) begin
            wait_len_next = i_wait_len;
        end
        if (entry && (state_next == ST_COUNT)) begin
            cnt_len_next = i_cnt_len;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_reg    <= ST_IDLE;
            sym_cnt_reg  <= '0;
            wait_len_reg <= '0;
            cnt_len_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            sym_cnt_reg  <= sym_cnt_next;
            wait_len_reg <= wait_len_next;
            cnt_len_reg  <= cnt_len_next;
        end
    end

    assign o_start_synchro           = (state_reg == ST_SYNC);
    assign o_prbs_cmp_curr_addr_done = (state_reg == ST_SYNC) && (period_cnt == PERIOD_LAST);
    assign o_start_ber_counter       = (state_reg == ST_COUNT);
    assign o_done                    = (state_reg == ST_DONE);
    assign o_sync_fail               = (state_reg == ST_FAIL);
    assign o_state                   = state_reg;

endmodule
